// File: rtl/merc16_alu_pkg.sv
// ============================================================================
// Module      : merc16_alu_pkg (package)
// Description : Shared definitions for the MERC-16 ALU and its iterative
//               multiply/divide sequencer. Holds the datapath width, the
//               3-bit ALU select codes, the sequencer op codes and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package merc16_alu_pkg;

  // Datapath width shared by the ALU and everything that drives it.
  localparam int MERC16_WIDTH = 16;

  // ALU select codes. The ALU decodes these same values.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_LSL  = 3'd5,
    ALU_LSR  = 3'd6,
    ALU_COMP = 3'd7
  } alu_sel_e;

  // Sequencer operation codes (the 'op' input).
  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_DIVU = 1'b1
  } seq_op_e;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage : merc16_alu_pkg

`default_nettype wire

// File: rtl/alu_muldiv_sequencer.sv
// ============================================================================
// Module      : alu_muldiv_sequencer
// Description : Iterative unsigned 16-bit multiply (low half of product) and
//               restoring divide (quotient + remainder) built on the shared
//               combinational ALU. Each step takes two cycles (P0/P1); the
//               sequencer drives the ALU operands/select and latches its
//               result back into its own working registers.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   ALU_SEQ_EARLY_EXIT_EN - when defined, MUL finishes as soon as the
//                           remaining multiplier bits are all zero
//                           (latency 2k+1, k = bit length of opb).
//                           Undefined: fixed 33-cycle latency for both ops.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request, sampled only while not busy
//   op           in   1      0 = MUL, 1 = DIVU
//   opa          in   WIDTH  multiplicand / dividend, captured on accept
//   opb          in   WIDTH  multiplier / divisor, captured on accept
//   busy         out  1      operation in flight
//   done         out  1      one-cycle pulse, results valid from this cycle
//   result       out  WIDTH  product[15:0] or quotient, held until next done
//   remainder    out  WIDTH  DIVU remainder, 0 after MUL
//   div_by_zero  out  1      DIVU with opb == 0, held with result
//   alu_a        out  WIDTH  ALU operand A
//   alu_b        out  WIDTH  ALU operand B
//   alu_s        out  3      ALU select
//   alu_r        in   WIDTH  ALU result
//   alu_lt       in   1      ALU unsigned A < B flag
// ============================================================================
`default_nettype none

module alu_muldiv_sequencer
  import merc16_alu_pkg::*;
#(
  parameter int WIDTH = MERC16_WIDTH,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_lt
);

  localparam int                  c_STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(STEPS - 1);

  seq_state_e          r_state;
  seq_state_e          w_state_next;
  logic [c_STEP_W-1:0] r_step;
  logic                r_phase;      // 0 = P0, 1 = P1
  seq_op_e             r_op;

  // MUL working registers
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_mplier;

  // DIVU working registers
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-1:0]    r_dvd;
  logic [WIDTH-1:0]    r_dvs;
  logic [WIDTH-1:0]    r_quo;
  logic                r_dbz;
  logic                r_ovf;        // bit shifted out of rem during P0

  // Output registers
  logic [WIDTH-1:0]    r_result;
  logic [WIDTH-1:0]    r_remainder;
  logic                r_div_by_zero;

  logic                w_accept;
  logic                w_take;
  logic [WIDTH-1:0]    w_rem_p1;
  logic [WIDTH-1:0]    w_quo_p1;

  // A new request is taken whenever nothing is in flight, including the
  // DONE cycle, so back-to-back operations lose no cycles.
  assign w_accept = start && (r_state != ST_RUN);

  // Restoring-divide subtract decision. The shifted remainder is one bit
  // wider than the ALU; if the bit shifted out was set, the true value is
  // at least 2^WIDTH, which always exceeds the divisor, so the subtraction
  // must be kept even though the truncated compare says otherwise.
  assign w_take   = !alu_lt || r_ovf;
  assign w_rem_p1 = w_take ? alu_r : r_rem;
  assign w_quo_p1 = {r_quo[WIDTH-2:0], w_take};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_next = ST_IDLE;
        if (start) begin
          w_state_next = ST_RUN;
`ifdef ALU_SEQ_EARLY_EXIT_EN
          // A zero multiplier has nothing to accumulate.
          if ((seq_op_e'(op) == OP_MUL) && (opb == '0)) begin
            w_state_next = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        if (r_phase) begin
          if (r_step == c_LAST_STEP) begin
            w_state_next = ST_DONE;
          end
`ifdef ALU_SEQ_EARLY_EXIT_EN
          // The multiplier is about to shift right; if no set bits remain
          // above bit 0, the next P0 would never add again.
          if ((r_op == OP_MUL) && (r_mplier[WIDTH-1:1] == '0)) begin
            w_state_next = ST_DONE;
          end
`endif
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: status flags and ALU drive
  // --------------------------------------------------------------------------
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    alu_a = '0;
    alu_b = '0;
    alu_s = ALU_ADD;
    case (r_state)
      ST_RUN: begin
        busy = 1'b1;
        if (r_op == OP_MUL) begin
          if (!r_phase) begin
            alu_a = r_acc;
            alu_b = r_mcand;
            alu_s = ALU_ADD;
          end else begin
            alu_a = r_mcand;
            alu_b = WIDTH'(1);
            alu_s = ALU_LSL;
          end
        end else begin
          if (!r_phase) begin
            alu_a = r_rem;
            alu_b = WIDTH'(1);
            alu_s = ALU_LSL;
          end else begin
            alu_a = r_rem;
            alu_b = r_dvs;
            alu_s = ALU_SUB;
          end
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= '0;
      r_phase  <= 1'b0;
      r_op     <= OP_MUL;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_quo    <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_step   <= '0;
      r_phase  <= 1'b0;
      r_op     <= seq_op_e'(op);
      r_acc    <= '0;
      r_mcand  <= opa;
      r_mplier <= opb;
      r_rem    <= '0;
      r_dvd    <= opa;
      r_dvs    <= opb;
      r_quo    <= '0;
      r_dbz    <= (seq_op_e'(op) == OP_DIVU) && (opb == '0);
      r_ovf    <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        r_step <= r_step + 1'b1;
      end
      if (r_op == OP_MUL) begin
        if (!r_phase) begin
          if (r_mplier[0]) begin
            r_acc <= alu_r;
          end
        end else begin
          r_mcand  <= alu_r;
          r_mplier <= r_mplier >> 1;
        end
      end else begin
        if (!r_phase) begin
          // Bring the next dividend bit into the freshly shifted remainder.
          r_ovf <= r_rem[WIDTH-1];
          r_rem <= {alu_r[WIDTH-1:1], alu_r[0] | r_dvd[WIDTH-1]};
          r_dvd <= r_dvd << 1;
        end else begin
          r_rem <= w_rem_p1;
          r_quo <= w_quo_p1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: loaded on the edge that enters DONE, so they are valid
  // during the done cycle and held until the next entry into DONE. The final
  // divide step is still being written on that edge, so its next values are
  // taken directly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result      <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_state_next == ST_DONE) begin
      if ((r_state == ST_RUN) && (r_op == OP_DIVU)) begin
        r_result      <= w_quo_p1;
        r_remainder   <= w_rem_p1;
        r_div_by_zero <= r_dbz;
      end else if (r_state == ST_RUN) begin
        r_result      <= r_acc;
        r_remainder   <= '0;
        r_div_by_zero <= 1'b0;
      end else begin
        // Zero-multiplier shortcut straight from accept.
        r_result      <= '0;
        r_remainder   <= '0;
        r_div_by_zero <= 1'b0;
      end
    end
  end

  assign result      = r_result;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule : alu_muldiv_sequencer

`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_alu_muldiv_sequencer
// Description : Self-checking bench for alu_muldiv_sequencer. Provides a
//               behavioural model of the combinational ALU on the sequencer's
//               ALU port, and compares results and latency against plain
//               arithmetic reference functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_s;
  logic [15:0] alu_r;
  logic        alu_lt;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_r       (alu_r),
    .alu_lt      (alu_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    case (alu_s)
      3'd0:    alu_r = alu_a + alu_b;
      3'd1:    alu_r = alu_a - alu_b;
      3'd2:    alu_r = alu_a & alu_b;
      3'd3:    alu_r = alu_a | alu_b;
      3'd4:    alu_r = alu_a ^ alu_b;
      3'd5:    alu_r = alu_a << alu_b[3:0];
      3'd6:    alu_r = alu_a >> alu_b[3:0];
      default: alu_r = ~alu_a;
    endcase
    alu_lt = (alu_a < alu_b);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_res(input logic o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (!o) begin
      p = 32'(a) * 32'(b);
      return p[15:0];
    end
    if (b == 16'd0) return 16'hFFFF;
    return a / b;
  endfunction

  function automatic logic [15:0] ref_rem(input logic o, input logic [15:0] a, input logic [15:0] b);
    if (!o) return 16'd0;
    if (b == 16'd0) return a;
    return a % b;
  endfunction

  function automatic int ref_lat(input logic o, input logic [15:0] b);
    int k;
    k = 0;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (!o) begin
      for (int i = 0; i < 16; i++) if ((b >> i) != 16'd0) k = i + 1;
      return 2 * k + 1;
    end
`endif
    return 33 + k;
  endfunction

  // Drives one request from the current (off-edge) time and returns the cycle
  // count from the accept edge to the first done, plus the outputs then.
  task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] res, output logic [15:0] rem,
                       output logic dbz);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = 16'($urandom); opb = 16'($urandom);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    res = result; rem = remainder; dbz = div_by_zero;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = 16'h1234; opb = 16'h5678;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || result !== 16'd0 || remainder !== 16'd0) begin
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b result=%h rem=%h, required all zero",
               busy, done, div_by_zero, result, remainder);
    end else n_pass++;
    n_checks++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_s !== 3'd0) begin
      $display("FAIL reset_alu_drive: a=%h b=%h s=%0d, required 0/0/0", alu_a, alu_b, alu_s);
    end else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end else n_pass++;
  endtask

  task automatic test_directed;
    int lat; logic [15:0] res, rem; logic dbz;
    logic [15:0] ta [4] = '{16'd3, 16'hFFFF, 16'd100, 16'd5};
    logic [15:0] tb [4] = '{16'd5, 16'hFFFF, 16'd7,   16'd0};
    logic        to [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      do_op(to[i], ta[i], tb[i], lat, res, rem, dbz);
      n_checks++;
      if (lat !== ref_lat(to[i], tb[i])) begin
        $display("FAIL dir%0d_latency: got %0d, required %0d", i, lat, ref_lat(to[i], tb[i]));
      end else n_pass++;
      n_checks++;
      if (res !== ref_res(to[i], ta[i], tb[i]) || rem !== ref_rem(to[i], ta[i], tb[i])) begin
        $display("FAIL dir%0d_value: result=%h rem=%h, required %h %h", i, res, rem,
                 ref_res(to[i], ta[i], tb[i]), ref_rem(to[i], ta[i], tb[i]));
      end else n_pass++;
      n_checks++;
      if (dbz !== (to[i] && tb[i] == 16'd0)) begin
        $display("FAIL dir%0d_div_by_zero: got %b, required %b", i, dbz, to[i] && tb[i] == 16'd0);
      end else n_pass++;
      n_checks++;
      if (busy !== 1'b0) begin
        $display("FAIL dir%0d_busy_in_done: got %b, required 0", i, busy);
      end else n_pass++;
      // Results must hold after the done pulse.
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || result !== ref_res(to[i], ta[i], tb[i]) || remainder !== ref_rem(to[i], ta[i], tb[i])) begin
        $display("FAIL dir%0d_hold: done=%b result=%h rem=%h, required 0 %h %h", i, done, result,
                 remainder, ref_res(to[i], ta[i], tb[i]), ref_rem(to[i], ta[i], tb[i]));
      end else n_pass++;
    end
  endtask

  task automatic test_random;
    int lat; logic [15:0] res, rem, a, b; logic o, dbz;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: b = 16'($urandom);
      endcase
      @(negedge clk);
      do_op(o, a, b, lat, res, rem, dbz);
      n_checks++;
      if (lat !== ref_lat(o, b) || res !== ref_res(o, a, b) || rem !== ref_rem(o, a, b) ||
          dbz !== (o && b == 16'd0)) begin
        $display("FAIL rand%0d op=%b a=%h b=%h: lat=%0d res=%h rem=%h dbz=%b, required %0d %h %h %b",
                 i, o, a, b, lat, res, rem, dbz, ref_lat(o, b), ref_res(o, a, b), ref_rem(o, a, b),
                 o && b == 16'd0);
      end else n_pass++;
    end
  endtask

  task automatic test_start_while_busy;
    int lat; int extra;
    @(negedge clk);
    op = 1'b0; opa = 16'd1234; opb = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      // Competing requests while the first MUL is in flight.
      if (c >= 2 && c <= 4) begin
        start = 1'b1; op = 1'b1; opa = 16'd99; opb = 16'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== ref_lat(1'b0, 16'd5) || result !== ref_res(1'b0, 16'd1234, 16'd5) ||
        remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      $display("FAIL busy_ignore: lat=%0d result=%h rem=%h dbz=%b, required %0d %h 0 0",
               lat, result, remainder, div_by_zero, ref_lat(1'b0, 16'd5), ref_res(1'b0, 16'd1234, 16'd5));
    end else n_pass++;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      $display("FAIL busy_ignore_no_second_op: %0d active cycles seen, required 0", extra);
    end else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; logic [15:0] r1, m1, r2, m2; logic d1, d2;
    @(negedge clk);
    do_op(1'b1, 16'd100, 16'd7, lat1, r1, m1, d1);
    // Still inside the DONE cycle: the next request is accepted here.
    do_op(1'b0, 16'hFFFF, 16'hFFFF, lat2, r2, m2, d2);
    n_checks++;
    if (lat1 !== 33 || r1 !== 16'd14 || m1 !== 16'd2) begin
      $display("FAIL b2b_first: lat=%0d result=%h rem=%h, required 33 000e 0002", lat1, r1, m1);
    end else n_pass++;
    n_checks++;
    if (lat2 !== ref_lat(1'b0, 16'hFFFF) || r2 !== 16'h0001 || m2 !== 16'd0 || d2 !== 1'b0) begin
      $display("FAIL b2b_second: lat=%0d result=%h rem=%h dbz=%b, required %0d 0001 0000 0",
               lat2, r2, m2, d2, ref_lat(1'b0, 16'hFFFF));
    end else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    int lat; int seen; logic [15:0] res, rem; logic dbz;
    @(negedge clk);
    do_op(1'b1, 16'd5, 16'd0, lat, res, rem, dbz);   // leaves nonzero held results
    @(negedge clk);
    op = 1'b0; opa = 16'd1000; opb = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || result !== 16'd0 || remainder !== 16'd0 ||
        alu_a !== 16'd0 || alu_b !== 16'd0 || alu_s !== 3'd0) begin
      $display("FAIL async_reset_mid_op: busy=%b done=%b dbz=%b result=%h rem=%h a=%h b=%h s=%0d, required all zero",
               busy, done, div_by_zero, result, remainder, alu_a, alu_b, alu_s);
    end else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL reset_no_done: %0d active cycles after abort, required 0", seen);
    end else n_pass++;
  endtask

  task automatic test_early_exit;
    int lat; logic [15:0] res, rem; logic dbz;
    @(negedge clk);
    do_op(1'b0, 16'd7, 16'd3, lat, res, rem, dbz);
    n_checks++;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (lat !== 5 || res !== 16'd21) begin
      $display("FAIL mul_opb3_latency: lat=%0d result=%h, required 5 0015", lat, res);
    end else n_pass++;
`else
    if (lat !== 33 || res !== 16'd21) begin
      $display("FAIL mul_opb3_latency: lat=%0d result=%h, required 33 0015", lat, res);
    end else n_pass++;
`endif
    @(negedge clk);
    do_op(1'b0, 16'hBEEF, 16'd0, lat, res, rem, dbz);
    n_checks++;
    if (lat !== ref_lat(1'b0, 16'd0) || res !== 16'd0 || rem !== 16'd0 || dbz !== 1'b0) begin
      $display("FAIL mul_opb0: lat=%0d result=%h rem=%h dbz=%b, required %0d 0 0 0",
               lat, res, rem, dbz, ref_lat(1'b0, 16'd0));
    end else n_pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_while_busy;
    test_back_to_back;
    test_early_exit;
    test_random;
    test_reset_mid_op;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_muldiv_sequencer

`default_nettype wire
